argmax_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 10-way argmax used in bid arbitration.
- Accepts one batch of N_BIDS bids through a valid/ready handshake, together with a per-bid mask and a max/min mode.
- Scans LANES bids per cycle and returns the winning index and value through an output valid/ready handshake.
- Sits between the bid collection stage and the award/grant logic.

---
 rtl/argmax_pkg.sv | 22 ++
 rtl/argmax_if.sv | 39 +++
 rtl/argmax_lane_cmp.sv | 51 +++++
 rtl/argmax_seq.sv | 167 ++++++++++++++++
 tb/tb_argmax_seq.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/argmax_pkg.sv
// argmax_pkg: shared types and default sizing for the sequential argmax block.
//   argmax_state_t : controller states (IDLE, SCAN, DONE)
//   argmax_mode_t  : selection mode (MODE_MAX picks largest, MODE_MIN picks smallest)
//   *_DEF          : default N_BIDS / BID_W / LANES used by the interface and the top.
package argmax_pkg;

    localparam int unsigned N_BIDS_DEF = 10;
    localparam int unsigned BID_W_DEF  = 17;
    localparam int unsigned LANES_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_t;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_MIN = 1'b1
    } argmax_mode_t;

endpackage

// File: rtl/argmax_if.sv
// argmax_if: batch-in / result-out handshake bundle for argmax_seq.
//   in_valid/in_ready   : batch handshake (bids, mask, mode qualified by in_valid)
//   in_bids[N_BIDS]     : unsigned bid values, index 0..N_BIDS-1
//   in_mask             : 1 = bid participates
//   in_mode             : 0 = argmax, 1 = argmin
//   out_valid/out_ready : result handshake
//   out_winner/value    : winning index and bid value
//   out_none            : no bid was masked in
// master = producer/consumer side, slave = argmax_seq.
interface argmax_if
    import argmax_pkg::*;
#(
    parameter int unsigned N_BIDS = N_BIDS_DEF,
    parameter int unsigned BID_W  = BID_W_DEF
) ();
    localparam int unsigned IDX_W = $clog2(N_BIDS);

    logic                             in_valid;
    logic                             in_ready;
    logic [N_BIDS-1:0][BID_W-1:0]     in_bids;
    logic [N_BIDS-1:0]                in_mask;
    logic                             in_mode;
    logic                             out_valid;
    logic                             out_ready;
    logic [IDX_W-1:0]                 out_winner;
    logic [BID_W-1:0]                 out_value;
    logic                             out_none;

    modport master (
        output in_valid, in_bids, in_mask, in_mode, out_ready,
        input  in_ready, out_valid, out_winner, out_value, out_none
    );

    modport slave (
        input  in_valid, in_bids, in_mask, in_mode, out_ready,
        output in_ready, out_valid, out_winner, out_value, out_none
    );

endinterface

// File: rtl/argmax_lane_cmp.sv
// argmax_lane_cmp: combinational reducer over LANES candidate bids.
//   base_i   : absolute index of lane 0
//   vals_i   : candidate values, lane 0 = lowest index
//   vlds_i   : lane participates (in range and masked in)
//   mode_i   : MODE_MAX / MODE_MIN
//   found_o  : at least one lane participated
//   idx_o    : absolute index of the chunk winner
//   value_o  : value of the chunk winner
// Lanes are visited in ascending order and only a strictly better value replaces
// the current pick, so ties go to the lowest index.
module argmax_lane_cmp
    import argmax_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned BID_W = BID_W_DEF,
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0]            base_i,
    input  logic [LANES-1:0][BID_W-1:0] vals_i,
    input  logic [LANES-1:0]            vlds_i,
    input  argmax_mode_t                mode_i,
    output logic                        found_o,
    output logic [IDX_W-1:0]            idx_o,
    output logic [BID_W-1:0]            value_o
);

    logic             found;
    logic [IDX_W-1:0] idx;
    logic [BID_W-1:0] value;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        value = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (vlds_i[l]) begin
                if (!found ||
                    ((mode_i == MODE_MIN) ? (vals_i[l] < value) : (vals_i[l] > value))) begin
                    found = 1'b1;
                    idx   = base_i + IDX_W'(l);
                    value = vals_i[l];
                end
            end
        end
    end

    assign found_o = found;
    assign idx_o   = idx;
    assign value_o = value;

endmodule

// File: rtl/argmax_seq.sv
// argmax_seq: multi-cycle masked argmax/argmin over one batch of N_BIDS bids.
//   clk     : clock, all state on posedge
//   rst_n   : asynchronous active-low reset
//   bus_io  : argmax_if slave (batch in, result out)
// A batch is captured in IDLE, scanned LANES bids per cycle in SCAN while a running
// best is kept, and the result is held in DONE until the consumer takes it.
module argmax_seq
    import argmax_pkg::*;
#(
    parameter int unsigned N_BIDS = N_BIDS_DEF,
    parameter int unsigned BID_W  = BID_W_DEF,
    parameter int unsigned LANES  = LANES_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    argmax_if.slave  bus_io
);

    localparam int unsigned IDX_W = $clog2(N_BIDS);
    // Wide enough for ptr + LANES - 1 so out-of-range lanes can be detected.
    localparam int unsigned PTR_W = $clog2(N_BIDS + LANES);

    argmax_state_t                state_q, state_d;
    logic                         rdy_q;
    logic [N_BIDS-1:0][BID_W-1:0] bids_q, bids_d;
    logic [N_BIDS-1:0]            mask_q, mask_d;
    argmax_mode_t                 mode_q, mode_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic                         best_found_q, best_found_d;
    logic [IDX_W-1:0]             best_idx_q, best_idx_d;
    logic [BID_W-1:0]             best_val_q, best_val_d;
    logic [IDX_W-1:0]             win_q, win_d;
    logic [BID_W-1:0]             val_q, val_d;
    logic                         none_q, none_d;

    logic                         in_ready;
    logic [PTR_W-1:0]             lane_idx;
    logic [LANES-1:0][BID_W-1:0]  lane_val;
    logic [LANES-1:0]             lane_vld;
    logic                         cmp_found;
    logic [PTR_W-1:0]             cmp_idx;
    logic [BID_W-1:0]             cmp_val;
    logic                         chunk_better;
    logic                         last_chunk;

    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready = rdy_q && (state_q == IDLE);

    // Gather the current chunk; lanes past the end of the batch never participate.
    always_comb begin
        lane_idx = '0;
        lane_val = '0;
        lane_vld = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_idx = ptr_q + PTR_W'(l);
            if (lane_idx < PTR_W'(N_BIDS)) begin
                lane_val[l] = bids_q[lane_idx[IDX_W-1:0]];
                lane_vld[l] = mask_q[lane_idx[IDX_W-1:0]];
            end
        end
    end

    argmax_lane_cmp #(
        .LANES (LANES),
        .BID_W (BID_W),
        .IDX_W (PTR_W)
    ) u_lane_cmp (
        .base_i  (ptr_q),
        .vals_i  (lane_val),
        .vlds_i  (lane_vld),
        .mode_i  (mode_q),
        .found_o (cmp_found),
        .idx_o   (cmp_idx),
        .value_o (cmp_val)
    );

    assign chunk_better = (mode_q == MODE_MIN) ? (cmp_val < best_val_q) : (cmp_val > best_val_q);
    assign last_chunk   = (ptr_q + PTR_W'(LANES)) >= PTR_W'(N_BIDS);

    always_comb begin
        state_d      = state_q;
        bids_d       = bids_q;
        mask_d       = mask_q;
        mode_d       = mode_q;
        ptr_d        = ptr_q;
        best_found_d = best_found_q;
        best_idx_d   = best_idx_q;
        best_val_d   = best_val_q;
        win_d        = win_q;
        val_d        = val_q;
        none_d       = none_q;

        unique case (state_q)
            IDLE: begin
                if (bus_io.in_valid && in_ready) begin
                    bids_d       = bus_io.in_bids;
                    mask_d       = bus_io.in_mask;
                    mode_d       = argmax_mode_t'(bus_io.in_mode);
                    ptr_d        = '0;
                    best_found_d = 1'b0;
                    // Zeroed so an empty mask reports winner 0 / value 0.
                    best_idx_d   = '0;
                    best_val_d   = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (cmp_found && (!best_found_q || chunk_better)) begin
                    best_found_d = 1'b1;
                    best_idx_d   = IDX_W'(cmp_idx);
                    best_val_d   = cmp_val;
                end
                if (last_chunk) begin
                    win_d   = best_idx_d;
                    val_d   = best_val_d;
                    none_d  = !best_found_d;
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(LANES);
                end
            end
            DONE: begin
                if (bus_io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rdy_q        <= 1'b0;
            bids_q       <= '0;
            mask_q       <= '0;
            mode_q       <= MODE_MAX;
            ptr_q        <= '0;
            best_found_q <= 1'b0;
            best_idx_q   <= '0;
            best_val_q   <= '0;
            win_q        <= '0;
            val_q        <= '0;
            none_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_q        <= 1'b1;
            bids_q       <= bids_d;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            ptr_q        <= ptr_d;
            best_found_q <= best_found_d;
            best_idx_q   <= best_idx_d;
            best_val_q   <= best_val_d;
            win_q        <= win_d;
            val_q        <= val_d;
            none_q       <= none_d;
        end
    end

    assign bus_io.in_ready   = in_ready;
    assign bus_io.out_valid  = (state_q == DONE);
    assign bus_io.out_winner = win_q;
    assign bus_io.out_value  = val_q;
    assign bus_io.out_none   = none_q;

endmodule

// File: tb/tb_argmax_seq.sv
// tb_argmax_seq: scoreboard bench for argmax_seq (defaults) plus a 7-bid / 3-lane instance.
module tb_argmax_seq;
    import argmax_pkg::*;

    localparam int unsigned N    = 10;
    localparam int unsigned W    = 17;
    localparam int unsigned L    = 2;
    localparam int unsigned LAT  = 5;
    localparam int unsigned N7   = 7;
    localparam int unsigned L7   = 3;
    localparam int unsigned LAT7 = 3;

    typedef struct {
        int unsigned winner;
        int unsigned value;
        bit          none;
        int unsigned acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    argmax_if #(.N_BIDS(N),  .BID_W(W)) bus  ();
    argmax_if #(.N_BIDS(N7), .BID_W(W)) bus7 ();

    argmax_seq #(.N_BIDS(N), .BID_W(W), .LANES(L)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    argmax_seq #(.N_BIDS(N7), .BID_W(W), .LANES(L7)) dut7 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus7)
    );

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    bit          bp_rand  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: find the extreme value among masked-in bids, then the lowest
    // index holding that value.
    function automatic exp_t model(input int unsigned b[10], input bit [9:0] m, input bit mode,
                                   input int n);
        exp_t        e;
        bit          any;
        int unsigned ext;
        any = 1'b0;
        ext = 0;
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                if (!any || (mode ? (b[i] < ext) : (b[i] > ext))) ext = b[i];
                any = 1'b1;
            end
        end
        e.none   = !any;
        e.winner = 0;
        e.value  = 0;
        e.acc    = 0;
        if (any) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (m[i] && b[i] == ext) e.winner = i;
            end
            e.value = ext;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_rand) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present a batch until accepted; push the expected result with its accept cycle.
    task automatic send(input int unsigned b[10], input bit [9:0] m, input bit mode,
                        input exp_t e_in);
        exp_t e;
        int   k;
        for (int i = 0; i < N; i++) bus.in_bids[i] = W'(b[i]);
        bus.in_mask  = m;
        bus.in_mode  = mode;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 300) begin
            tick();
            k++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
            bus.in_valid = 1'b0;
            return;
        end
        e     = e_in;
        e.acc = cyc + 1;
        sb.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        // Scramble inputs after capture; the result must not change.
        for (int i = 0; i < N; i++) bus.in_bids[i] = W'($urandom);
        bus.in_mask = N'($urandom);
        bus.in_mode = 1'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 600) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every cycle a result is shown it must match the scoreboard head.
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: out_valid=1 winner=%0d, expected no result",
                         bus.out_winner);
            end else begin : cmp
                exp_t e;
                e = sb[0];
                if (!prev_v) check("latency", 64'(cyc - e.acc), 64'(LAT));
                check("out_winner", 64'(bus.out_winner), 64'(e.winner));
                check("out_value", 64'(bus.out_value), 64'(e.value));
                check("out_none", 64'(bus.out_none), 64'(e.none));
                check("in_ready_in_done", 64'(bus.in_ready), 64'(0));
                if (bus.out_ready) void'(sb.pop_front());
            end
            prev_v = 1'b1;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic run7(input int unsigned b[10], input bit [9:0] m, input bit mode,
                        input exp_t e);
        int unsigned acc;
        int          k;
        for (int i = 0; i < N7; i++) bus7.in_bids[i] = W'(b[i]);
        bus7.in_mask  = m[N7-1:0];
        bus7.in_mode  = mode;
        bus7.in_valid = 1'b1;
        k = 0;
        while (!bus7.in_ready && k < 50) begin
            tick();
            k++;
        end
        acc = cyc + 1;
        tick();
        bus7.in_valid = 1'b0;
        bus7.in_bids  = '0;
        k = 0;
        while (!bus7.out_valid && k < 50) begin
            tick();
            k++;
        end
        check("n7_latency", 64'(cyc - acc), 64'(LAT7));
        check("n7_winner", 64'(bus7.out_winner), 64'(e.winner));
        check("n7_value", 64'(bus7.out_value), 64'(e.value));
        check("n7_none", 64'(bus7.out_none), 64'(e.none));
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned bb[10];
        bit [9:0]    mm;
        bit          md;
        exp_t        ex;

        bus.in_valid  = 1'b0;
        bus.in_bids   = '0;
        bus.in_mask   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        bus7.in_valid  = 1'b0;
        bus7.in_bids   = '0;
        bus7.in_mask   = '0;
        bus7.in_mode   = 1'b0;
        bus7.out_ready = 1'b1;

        // Reset values.
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_winner", 64'(bus.out_winner), 64'(0));
        check("rst_out_value", 64'(bus.out_value), 64'(0));
        check("rst_out_none", 64'(bus.out_none), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rel_in_ready_before_edge", 64'(bus.in_ready), 64'(0));
        tick();
        check("rel_in_ready", 64'(bus.in_ready), 64'(1));

        // One-hot sweep, max mode, all masked in.
        for (int i = 0; i < N; i++) begin
            bb = '{default: 0};
            bb[i] = 100;
            send(bb, '1, 1'b0, '{winner: i, value: 100, none: 0, acc: 0});
            drain();
        end

        // Ties and mode.
        bb = '{default: 7};
        send(bb, '1, 1'b0, '{winner: 0, value: 7, none: 0, acc: 0});
        bb = '{5, 3, 9, 3, 8, 3, 9, 4, 6, 3};
        send(bb, '1, 1'b1, '{winner: 1, value: 3, none: 0, acc: 0});
        send(bb, '1, 1'b0, '{winner: 2, value: 9, none: 0, acc: 0});
        // Mask.
        send(bb, 10'b1110111011, 1'b0, '{winner: 4, value: 8, none: 0, acc: 0});
        send(bb, 10'b0, 1'b0, '{winner: 0, value: 0, none: 1, acc: 0});
        bb = '{default: 0};
        send(bb, '1, 1'b1, '{winner: 0, value: 0, none: 0, acc: 0});
        bb = '{default: 17'h1FFFF};
        bb[3] = 17'h1FFFE;
        send(bb, '1, 1'b1, '{winner: 3, value: 17'h1FFFE, none: 0, acc: 0});
        send(bb, 10'b1111110111, 1'b0, '{winner: 0, value: 17'h1FFFF, none: 0, acc: 0});
        drain();

        // Backpressure: hold the result, offer a second batch meanwhile.
        bus.out_ready = 1'b0;
        bb = '{5, 3, 9, 3, 8, 3, 9, 4, 6, 3};
        send(bb, '1, 1'b0, '{winner: 2, value: 9, none: 0, acc: 0});
        begin
            int k;
            k = 0;
            while (!bus.out_valid && k < 50) begin
                tick();
                k++;
            end
        end
        for (int i = 0; i < N; i++) bus.in_bids[i] = W'(i + 1);
        bus.in_mask  = '1;
        bus.in_mode  = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) begin
            tick();
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_in_ready_after_hs", 64'(bus.in_ready), 64'(1));
        ex = '{winner: 0, value: 1, none: 0, acc: 0};
        ex.acc = cyc + 1;
        sb.push_back(ex);
        tick();
        bus.in_valid = 1'b0;
        drain();

        // Reset two cycles into SCAN discards the batch.
        bb = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        send(bb, '1, 1'b0, '{winner: 9, value: 10, none: 0, acc: 0});
        tick();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        check("midrst_out_winner", 64'(bus.out_winner), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        check("midrst_in_ready_before_edge", 64'(bus.in_ready), 64'(0));
        tick();
        check("midrst_in_ready_after", 64'(bus.in_ready), 64'(1));
        bb = '{4, 40, 400, 4000, 40000, 4, 40, 400, 4000, 40000};
        send(bb, '1, 1'b0, '{winner: 4, value: 40000, none: 0, acc: 0});
        repeat (8) tick();
        drain();

        // Randomised batches with random backpressure.
        bp_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                bb[i] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7)
                                                    : $urandom_range(0, 17'h1FFFF);
            end
            mm = ($urandom_range(0, 9) == 0) ? 10'b0 : 10'($urandom);
            md = 1'($urandom);
            send(bb, mm, md, model(bb, mm, md, N));
        end
        drain();
        bp_rand = 1'b0;
        bus.out_ready = 1'b1;

        // Partial final chunk: 7 bids, 3 lanes.
        for (int i = 0; i < N7; i++) bb[i] = $urandom_range(0, 17'h1FFFE);
        bb[6] = 17'h1FFFF;
        run7(bb, '1, 1'b0, '{winner: 6, value: 17'h1FFFF, none: 0, acc: 0});
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N7; i++) bb[i] = $urandom_range(0, 15);
            mm = 10'($urandom);
            md = 1'($urandom);
            run7(bb, mm, md, model(bb, mm, md, N7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
